// File: rtl/modulo_pago.sv
// ---------------------------------------------------------------------------
// modulo_pago
// Payment responder for the coffee-machine controller. Latches a price when
// the beverage FSM issues a charge request, accumulates coins from the coin
// acceptor, and reports payment (with change) or a full refund on cancel or
// inactivity timeout. All amounts are in 50-colon units.
//
// Ports:
//   clk              in   system clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   precio[3:0]      in   price code (0001..1000 valid)
//   cobrar           in   charge request, sampled in IDLE
//   cancelar         in   user cancel, sampled in COBRANDO
//   moneda_valida    in   coin strobe, one coin per asserted cycle
//   moneda[1:0]      in   coin value 01=50, 10=100, 11=500, 00=reject
//   PAGO_RECIBIDO    out  one-cycle pulse, price covered
//   cambio[6:0]      out  change / refund amount
//   cambio_valido    out  one-cycle pulse qualifying cambio
//   devolucion       out  one-cycle pulse, refund (cancel/timeout)
//   monto_acumulado  out  running credit
//   ocupado          out  high while a transaction is in progress
//   error_precio     out  one-cycle pulse, invalid price on cobrar
//   moneda_rechazada out  one-cycle pulse, coin not accepted
// ---------------------------------------------------------------------------
module modulo_pago #(
    parameter logic [7:0] TIMEOUT = 8'd10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] precio,
    input  logic       cobrar,
    input  logic       cancelar,
    input  logic       moneda_valida,
    input  logic [1:0] moneda,
    output logic       PAGO_RECIBIDO,
    output logic [6:0] cambio,
    output logic       cambio_valido,
    output logic       devolucion,
    output logic [6:0] monto_acumulado,
    output logic       ocupado,
    output logic       error_precio,
    output logic       moneda_rechazada
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COBRANDO = 2'd1,
        PAGADO   = 2'd2,
        DEVOLVER = 2'd3
    } state_t;

    state_t     r_state, w_state_next;
    logic [6:0] r_target, w_target_next;
    logic [6:0] r_monto, w_monto_next;
    logic [7:0] r_timer, w_timer_next;
    logic [6:0] r_cambio, w_cambio_next;
    logic       r_pago, w_pago_next;
    logic       r_cambio_valido, w_cambio_valido_next;
    logic       r_devolucion, w_devolucion_next;
    logic       r_ocupado, w_ocupado_next;
    logic       r_error_precio, w_error_precio_next;
    logic       r_rechazada, w_rechazada_next;

    logic [6:0] w_price_units;
    logic       w_price_ok;
    logic [6:0] w_coin_units;
    logic       w_coin_ok;
    logic [6:0] w_suma;
    logic [7:0] w_timer_last;

    // Price code to target credit.
    always_comb begin
        w_price_units = 7'd0;
        w_price_ok    = 1'b1;
        case (precio)
            4'b0001: w_price_units = 7'd10;
            4'b0010: w_price_units = 7'd20;
            4'b0011: w_price_units = 7'd30;
            4'b0100: w_price_units = 7'd15;
            4'b0101: w_price_units = 7'd25;
            4'b0110: w_price_units = 7'd35;
            4'b0111: w_price_units = 7'd40;
            4'b1000: w_price_units = 7'd45;
            default: w_price_ok    = 1'b0;
        endcase
    end

    always_comb begin
        w_coin_units = 7'd0;
        case (moneda)
            2'b01:   w_coin_units = 7'd1;
            2'b10:   w_coin_units = 7'd2;
            2'b11:   w_coin_units = 7'd10;
            default: w_coin_units = 7'd0;
        endcase
    end

    assign w_coin_ok    = moneda_valida && (moneda != 2'b00);
    // Credit including this cycle's coin; at most 44 + 10, so 7 bits suffice.
    assign w_suma       = r_monto + (w_coin_ok ? w_coin_units : 7'd0);
    assign w_timer_last = TIMEOUT - 8'd1;

    always_comb begin
        w_state_next         = r_state;
        w_target_next        = r_target;
        w_monto_next         = r_monto;
        w_timer_next         = r_timer;
        w_cambio_next        = r_cambio;
        w_pago_next          = 1'b0;
        w_cambio_valido_next = 1'b0;
        w_devolucion_next    = 1'b0;
        w_error_precio_next  = 1'b0;
        w_rechazada_next     = 1'b0;

        case (r_state)
            IDLE: begin
                w_rechazada_next = moneda_valida;
                if (cobrar) begin
                    if (w_price_ok) begin
                        w_target_next = w_price_units;
                        w_monto_next  = 7'd0;
                        w_timer_next  = 8'd0;
                        w_cambio_next = 7'd0;
                        w_state_next  = COBRANDO;
                    end else begin
                        w_error_precio_next = 1'b1;
                    end
                end
            end
            COBRANDO: begin
                w_rechazada_next = moneda_valida && (moneda == 2'b00);
                // Payment outranks cancel and timeout so a covering coin is
                // never refunded.
                if (w_suma >= r_target) begin
                    w_state_next         = PAGADO;
                    w_cambio_next        = w_suma - r_target;
                    w_monto_next         = w_suma;
                    w_pago_next          = 1'b1;
                    w_cambio_valido_next = 1'b1;
                end else if (cancelar) begin
                    w_state_next         = DEVOLVER;
                    w_cambio_next        = w_suma;
                    w_devolucion_next    = 1'b1;
                    w_cambio_valido_next = 1'b1;
                end else if (!w_coin_ok && (r_timer == w_timer_last)) begin
                    w_state_next         = DEVOLVER;
                    w_cambio_next        = r_monto;
                    w_devolucion_next    = 1'b1;
                    w_cambio_valido_next = 1'b1;
                end else begin
                    w_monto_next = w_suma;
                    // Rejected coins do not count as activity.
                    w_timer_next = w_coin_ok ? 8'd0 : r_timer + 8'd1;
                end
            end
            PAGADO, DEVOLVER: begin
                w_rechazada_next = moneda_valida;
                w_monto_next     = 7'd0;
                w_state_next     = IDLE;
            end
            default: w_state_next = IDLE;
        endcase

        w_ocupado_next = (w_state_next != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_target        <= 7'd0;
            r_monto         <= 7'd0;
            r_timer         <= 8'd0;
            r_cambio        <= 7'd0;
            r_pago          <= 1'b0;
            r_cambio_valido <= 1'b0;
            r_devolucion    <= 1'b0;
            r_ocupado       <= 1'b0;
            r_error_precio  <= 1'b0;
            r_rechazada     <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_target        <= w_target_next;
            r_monto         <= w_monto_next;
            r_timer         <= w_timer_next;
            r_cambio        <= w_cambio_next;
            r_pago          <= w_pago_next;
            r_cambio_valido <= w_cambio_valido_next;
            r_devolucion    <= w_devolucion_next;
            r_ocupado       <= w_ocupado_next;
            r_error_precio  <= w_error_precio_next;
            r_rechazada     <= w_rechazada_next;
        end
    end

    assign PAGO_RECIBIDO    = r_pago;
    assign cambio           = r_cambio;
    assign cambio_valido    = r_cambio_valido;
    assign devolucion       = r_devolucion;
    assign monto_acumulado  = r_monto;
    assign ocupado          = r_ocupado;
    assign error_precio     = r_error_precio;
    assign moneda_rechazada = r_rechazada;

endmodule

// File: tb/tb_modulo_pago.sv
// ---------------------------------------------------------------------------
// tb_modulo_pago
// Self-checking bench for modulo_pago: directed scenarios followed by
// randomized transactions checked against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_modulo_pago;

    localparam int TIMEOUT_P = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] precio = 4'd0;
    logic       cobrar = 1'b0;
    logic       cancelar = 1'b0;
    logic       moneda_valida = 1'b0;
    logic [1:0] moneda = 2'd0;
    logic       PAGO_RECIBIDO;
    logic [6:0] cambio;
    logic       cambio_valido;
    logic       devolucion;
    logic [6:0] monto_acumulado;
    logic       ocupado;
    logic       error_precio;
    logic       moneda_rechazada;

    int n_cmp = 0;
    int n_bad = 0;

    modulo_pago #(.TIMEOUT(8'(TIMEOUT_P))) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .precio           (precio),
        .cobrar           (cobrar),
        .cancelar         (cancelar),
        .moneda_valida    (moneda_valida),
        .moneda           (moneda),
        .PAGO_RECIBIDO    (PAGO_RECIBIDO),
        .cambio           (cambio),
        .cambio_valido    (cambio_valido),
        .devolucion       (devolucion),
        .monto_acumulado  (monto_acumulado),
        .ocupado          (ocupado),
        .error_precio     (error_precio),
        .moneda_rechazada (moneda_rechazada)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference tables.
    function automatic int price_units(input logic [3:0] code);
        case (code)
            4'd1: return 10;
            4'd2: return 20;
            4'd3: return 30;
            4'd4: return 15;
            4'd5: return 25;
            4'd6: return 35;
            4'd7: return 40;
            4'd8: return 45;
            default: return 0;
        endcase
    endfunction

    function automatic int coin_units(input logic [1:0] m);
        case (m)
            2'd1: return 1;
            2'd2: return 2;
            2'd3: return 10;
            default: return 0;
        endcase
    endfunction

    // Apply inputs for one clock edge; outputs are observed 1 ns after it.
    task automatic drive(input logic cob, input logic [3:0] p, input logic vld,
                         input logic [1:0] m, input logic canc);
        cobrar = cob; precio = p; moneda_valida = vld; moneda = m; cancelar = canc;
        @(posedge clk); #1;
        cobrar = 1'b0; moneda_valida = 1'b0; moneda = 2'd0; cancelar = 1'b0;
    endtask

    function automatic logic [19:0] all_outs();
        return {PAGO_RECIBIDO, cambio, cambio_valido, devolucion, monto_acumulado,
                ocupado, error_precio, moneda_rechazada};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        #7;
        n_cmp++;
        if (all_outs() !== 20'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", all_outs());
        end
        #15 reset_n = 1'b1;
        drive(0, 4'd0, 1, 2'd3, 0);
        n_cmp++;
        if ({moneda_rechazada, monto_acumulado, ocupado} !== {1'b1, 7'd0, 1'b0}) begin
            n_bad++; $display("FAIL idle_coin_reject: rech=%b monto=%0d ocup=%b want 1/0/0",
                              moneda_rechazada, monto_acumulado, ocupado);
        end
        $display("test_reset done");
    endtask

    task automatic test_exact_payment();
        drive(1, 4'b0001, 0, 2'd0, 0);
        n_cmp++;
        if ({ocupado, monto_acumulado} !== {1'b1, 7'd0}) begin
            n_bad++; $display("FAIL exact_start: ocup=%b monto=%0d want 1/0", ocupado, monto_acumulado);
        end
        for (int i = 1; i <= 5; i++) begin
            drive(0, 4'd0, 1, 2'b10, 0);
            n_cmp++;
            if (i < 5 && (monto_acumulado !== 7'(2*i) || PAGO_RECIBIDO !== 1'b0)) begin
                n_bad++; $display("FAIL exact_accum%0d: monto=%0d pago=%b want %0d/0",
                                  i, monto_acumulado, PAGO_RECIBIDO, 2*i);
            end
            if (i == 5 && {PAGO_RECIBIDO, cambio_valido, devolucion, cambio, monto_acumulado}
                          !== {1'b1, 1'b1, 1'b0, 7'd0, 7'd10}) begin
                n_bad++; $display("FAIL exact_paid: pago=%b cv=%b dev=%b cambio=%0d monto=%0d want 1/1/0/0/10",
                                  PAGO_RECIBIDO, cambio_valido, devolucion, cambio, monto_acumulado);
            end
        end
        // Coin offered during the PAGADO cycle must be rejected.
        drive(0, 4'd0, 1, 2'b11, 0);
        n_cmp++;
        if ({PAGO_RECIBIDO, cambio_valido, moneda_rechazada, ocupado, monto_acumulado}
            !== {1'b0, 1'b0, 1'b1, 1'b0, 7'd0}) begin
            n_bad++; $display("FAIL exact_after: pago=%b cv=%b rech=%b ocup=%b monto=%0d want 0/0/1/0/0",
                              PAGO_RECIBIDO, cambio_valido, moneda_rechazada, ocupado, monto_acumulado);
        end
        $display("test_exact_payment done");
    endtask

    task automatic test_overpay();
        drive(1, 4'b1000, 0, 2'd0, 0);
        for (int i = 1; i <= 5; i++) begin
            drive(0, 4'd0, 1, 2'b11, 0);
            n_cmp++;
            if (devolucion !== 1'b0 || PAGO_RECIBIDO !== (i == 5)) begin
                n_bad++; $display("FAIL overpay_pulse%0d: pago=%b dev=%b want %b/0",
                                  i, PAGO_RECIBIDO, devolucion, (i == 5));
            end
        end
        n_cmp++;
        if ({cambio, monto_acumulado} !== {7'd5, 7'd50}) begin
            n_bad++; $display("FAIL overpay_change: cambio=%0d monto=%0d want 5/50", cambio, monto_acumulado);
        end
        drive(0, 4'd0, 0, 2'd0, 0);
        $display("test_overpay done");
    endtask

    task automatic test_timeout();
        drive(1, 4'b0011, 0, 2'd0, 0);
        drive(0, 4'd0, 1, 2'b11, 0);
        for (int e = 1; e <= TIMEOUT_P; e++) begin
            drive(0, 4'd0, 0, 2'd0, 0);
            n_cmp++;
            if (e < TIMEOUT_P && (devolucion !== 1'b0 || ocupado !== 1'b1)) begin
                n_bad++; $display("FAIL timeout_early%0d: dev=%b ocup=%b want 0/1", e, devolucion, ocupado);
            end
            if (e == TIMEOUT_P && {devolucion, cambio_valido, PAGO_RECIBIDO, cambio}
                                  !== {1'b1, 1'b1, 1'b0, 7'd10}) begin
                n_bad++; $display("FAIL timeout_refund: dev=%b cv=%b pago=%b cambio=%0d want 1/1/0/10",
                                  devolucion, cambio_valido, PAGO_RECIBIDO, cambio);
            end
        end
        drive(0, 4'd0, 0, 2'd0, 0);
        n_cmp++;
        if ({devolucion, ocupado, monto_acumulado, cambio} !== {1'b0, 1'b0, 7'd0, 7'd10}) begin
            n_bad++; $display("FAIL timeout_idle: dev=%b ocup=%b monto=%0d cambio=%0d want 0/0/0/10",
                              devolucion, ocupado, monto_acumulado, cambio);
        end
        $display("test_timeout done");
    endtask

    task automatic test_bad_price();
        drive(1, 4'b1001, 0, 2'd0, 0);
        n_cmp++;
        if ({error_precio, ocupado} !== 2'b10) begin
            n_bad++; $display("FAIL bad_price: err=%b ocup=%b want 1/0", error_precio, ocupado);
        end
        drive(1, 4'b0100, 0, 2'd0, 0);
        n_cmp++;
        if ({error_precio, ocupado} !== 2'b01) begin
            n_bad++; $display("FAIL good_after_bad: err=%b ocup=%b want 0/1", error_precio, ocupado);
        end
        // Cancel with no credit: zero-amount refund.
        drive(0, 4'd0, 0, 2'd0, 1);
        n_cmp++;
        if ({devolucion, cambio_valido, cambio} !== {1'b1, 1'b1, 7'd0}) begin
            n_bad++; $display("FAIL zero_refund: dev=%b cv=%b cambio=%0d want 1/1/0",
                              devolucion, cambio_valido, cambio);
        end
        drive(0, 4'd0, 0, 2'd0, 0);
        $display("test_bad_price done");
    endtask

    task automatic test_cancel_race();
        drive(1, 4'b0100, 0, 2'd0, 0);
        drive(0, 4'd0, 1, 2'b11, 0);
        drive(0, 4'd0, 1, 2'b10, 1);
        n_cmp++;
        if ({devolucion, PAGO_RECIBIDO, cambio} !== {1'b1, 1'b0, 7'd12}) begin
            n_bad++; $display("FAIL cancel_with_coin: dev=%b pago=%b cambio=%0d want 1/0/12",
                              devolucion, PAGO_RECIBIDO, cambio);
        end
        drive(0, 4'd0, 0, 2'd0, 0);
        drive(1, 4'b0100, 0, 2'd0, 0);
        n_cmp++;
        if (cambio !== 7'd0) begin
            n_bad++; $display("FAIL cambio_clear_on_cobrar: cambio=%0d want 0", cambio);
        end
        drive(0, 4'd0, 1, 2'b11, 0);
        drive(0, 4'd0, 1, 2'b11, 1);
        n_cmp++;
        if ({PAGO_RECIBIDO, devolucion, cambio, monto_acumulado} !== {1'b1, 1'b0, 7'd5, 7'd20}) begin
            n_bad++; $display("FAIL pay_beats_cancel: pago=%b dev=%b cambio=%0d monto=%0d want 1/0/5/20",
                              PAGO_RECIBIDO, devolucion, cambio, monto_acumulado);
        end
        drive(0, 4'd0, 0, 2'd0, 0);
        $display("test_cancel_race done");
    endtask

    task automatic test_reset_mid();
        drive(1, 4'b0001, 0, 2'd0, 0);
        for (int i = 0; i < 3; i++) drive(0, 4'd0, 1, 2'b10, 0);
        n_cmp++;
        if (monto_acumulado !== 7'd6) begin
            n_bad++; $display("FAIL reset_mid_credit: monto=%0d want 6", monto_acumulado);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (all_outs() !== 20'd0) begin
            n_bad++; $display("FAIL reset_mid_async: got %h want 0", all_outs());
        end
        @(posedge clk); #3 reset_n = 1'b1;
        drive(0, 4'd0, 0, 2'd0, 0);
        n_cmp++;
        if ({ocupado, devolucion, monto_acumulado} !== {1'b0, 1'b0, 7'd0}) begin
            n_bad++; $display("FAIL reset_mid_idle: ocup=%b dev=%b monto=%0d want 0/0/0",
                              ocupado, devolucion, monto_acumulado);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_reject_timer();
        drive(1, 4'b0011, 0, 2'd0, 0);
        drive(0, 4'd0, 1, 2'b01, 0);
        for (int i = 0; i < 5; i++) drive(0, 4'd0, 0, 2'd0, 0);
        drive(0, 4'd0, 1, 2'b00, 0);
        n_cmp++;
        if ({moneda_rechazada, monto_acumulado, devolucion} !== {1'b1, 7'd1, 1'b0}) begin
            n_bad++; $display("FAIL reject_in_cobrando: rech=%b monto=%0d dev=%b want 1/1/0",
                              moneda_rechazada, monto_acumulado, devolucion);
        end
        // Coin arrived 6 edges ago; refund expected at edge TIMEOUT after it.
        for (int e = 7; e <= TIMEOUT_P; e++) begin
            drive(0, 4'd0, 0, 2'd0, 0);
            n_cmp++;
            if (devolucion !== (e == TIMEOUT_P)) begin
                n_bad++; $display("FAIL reject_timer_edge%0d: dev=%b want %b", e, devolucion, (e == TIMEOUT_P));
            end
        end
        n_cmp++;
        if (cambio !== 7'd1) begin
            n_bad++; $display("FAIL reject_timer_refund: cambio=%0d want 1", cambio);
        end
        drive(0, 4'd0, 0, 2'd0, 0);
        $display("test_reject_timer done");
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic [3:0] code;
            int target, credit, quiet, cyc;
            bit done;
            code   = 4'($urandom_range(1, 8));
            target = price_units(code);
            drive(1, code, 0, 2'd0, 0);
            n_cmp++;
            if ({ocupado, monto_acumulado} !== {1'b1, 7'd0}) begin
                n_bad++; $display("FAIL rand_start t%0d: ocup=%b monto=%0d want 1/0", t, ocupado, monto_acumulado);
            end
            credit = 0; quiet = 0; done = 0; cyc = 0;
            while (!done && cyc < 200) begin
                int r, add, exp_chg;
                bit vld, canc, acc, exp_pay, exp_dev;
                logic [1:0] m;
                r = $urandom_range(0, 99);
                vld = (r < 48);
                m = (r < 40) ? 2'($urandom_range(1, 3)) : 2'd0;
                canc = ($urandom_range(0, 99) < 4);
                acc = vld && (m != 2'd0);
                add = acc ? coin_units(m) : 0;
                exp_pay = 0; exp_dev = 0; exp_chg = 0;
                if (credit + add >= target) begin
                    exp_pay = 1; exp_chg = credit + add - target;
                end else if (canc) begin
                    exp_dev = 1; exp_chg = credit + add;
                end else if (!acc && quiet + 1 == TIMEOUT_P) begin
                    exp_dev = 1; exp_chg = credit;
                end
                drive(0, 4'd0, vld, m, canc);
                cyc++;
                n_cmp++;
                if ({PAGO_RECIBIDO, devolucion, cambio_valido, moneda_rechazada}
                    !== {exp_pay, exp_dev, exp_pay | exp_dev, vld && !acc}) begin
                    n_bad++; $display("FAIL rand_pulses t%0d c%0d: pago=%b dev=%b cv=%b rech=%b want %b/%b/%b/%b",
                                      t, cyc, PAGO_RECIBIDO, devolucion, cambio_valido, moneda_rechazada,
                                      exp_pay, exp_dev, exp_pay | exp_dev, vld && !acc);
                end
                if (exp_pay || exp_dev) begin
                    done = 1;
                    n_cmp++;
                    if (cambio !== 7'(exp_chg)) begin
                        n_bad++; $display("FAIL rand_cambio t%0d: cambio=%0d want %0d", t, cambio, exp_chg);
                    end
                    if (exp_pay) begin
                        n_cmp++;
                        if (monto_acumulado !== 7'(credit + add)) begin
                            n_bad++; $display("FAIL rand_paid_monto t%0d: monto=%0d want %0d",
                                              t, monto_acumulado, credit + add);
                        end
                    end
                end else begin
                    credit += add;
                    quiet = acc ? 0 : quiet + 1;
                    n_cmp++;
                    if ({monto_acumulado, ocupado} !== {7'(credit), 1'b1}) begin
                        n_bad++; $display("FAIL rand_monto t%0d c%0d: monto=%0d ocup=%b want %0d/1",
                                          t, cyc, monto_acumulado, ocupado, credit);
                    end
                end
            end
            if (!done) begin
                n_cmp++; n_bad++;
                $display("FAIL rand_no_completion t%0d: no payment or refund within 200 cycles", t);
            end
            drive(0, 4'd0, 0, 2'd0, 0);
            n_cmp++;
            if ({ocupado, monto_acumulado} !== {1'b0, 7'd0}) begin
                n_bad++; $display("FAIL rand_end t%0d: ocup=%b monto=%0d want 0/0", t, ocupado, monto_acumulado);
            end
            $display("random transaction %0d price=%0d done", t, target);
        end
    endtask

    initial begin
        test_reset();
        test_exact_payment();
        test_overpay();
        test_timeout();
        test_bad_price();
        test_cancel_race();
        test_reset_mid();
        test_reject_timer();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
